// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS fetch stage.
// Consumers import mips_fetch_pkg::*.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        RESET_WAIT,
        FETCH,
        HOLD,
        ERR
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    // Field widths of the I-type immediate and the J-type index
    localparam int IMM16  = 16;
    localparam int JIDX26 = 26;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jr > jmp > branch > sequential.
// Raw target is returned; alignment policy lives in the fetch unit.
module next_pc_calc
    import mips_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        br_taken,
    input  logic        jmp,
    input  logic        jr,
    input  logic [31:0] rs_val,
    output logic [31:0] next_pc
);

    logic [31:0] br_off;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic        unused_hi;

    assign br_off = {{(32-IMM16-2){instr[IMM16-1]}},
                     instr[IMM16-1:0], 2'b00};
    assign br_tgt = pc_plus4 + br_off;
    assign j_tgt  = {pc_plus4[31:28], instr[JIDX26-1:0], 2'b00};

    assign unused_hi = ^instr[31:JIDX26];

    // Several selects may be high together; order encodes priority
    always_comb begin
        next_pc = pc_plus4;
        priority case (1'b1)
            jr:       next_pc = rs_val;
            jmp:      next_pc = j_tgt;
            br_taken: next_pc = br_tgt;
            default:  next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch over a req/ack handshake.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned targets into ERR.
module pc_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        br_taken,
    input  logic        jmp,
    input  logic        jr,
    input  logic [31:0] rs_val,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retire_cnt,
    output logic        fetch_err
);

    fetch_state_t state;
    logic [31:0]  npc_raw;
    logic [31:0]  npc;
    logic         misalign;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    next_pc_calc u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .br_taken (br_taken),
        .jmp      (jmp),
        .jr       (jr),
        .rs_val   (rs_val),
        .next_pc  (npc_raw)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    assign npc      = npc_raw;
    assign misalign = |npc_raw[1:0];
`else
    logic unused_lo;
    assign unused_lo = ^npc_raw[1:0];
    assign npc       = {npc_raw[31:2], 2'b00};
    assign misalign  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RESET_WAIT;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            retire_cnt  <= 32'd0;
            fetch_err   <= 1'b0;
        end else begin
            unique case (state)
                RESET_WAIT: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        retire_cnt  <= retire_cnt + 32'd1;
                        instr_valid <= 1'b0;
                        // A bad target still retires the current instr
                        if (misalign) begin
                            fetch_err <= 1'b1;
                            state     <= ERR;
                        end else begin
                            pc       <= npc;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                ERR: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: state <= RESET_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus queues expected fetches,
// a monitor pops and compares on each new request and each new instr.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_taken;
    logic        jmp;
    logic        jr;
    logic [31:0] rs_val;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retire_cnt;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;
    int lat = 0;
    int wait_cnt = 0;
    int n_ret = 0;
    bit mem_en = 1'b1;

    logic [31:0] exp_fetch_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_ins_q[$];
    logic        req_d = 1'b0;
    logic        valid_d = 1'b0;
    logic [31:0] cur_addr = 32'd0;

    pc_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .br_taken    (br_taken),
        .jmp         (jmp),
        .jr          (jr),
        .rs_val      (rs_val),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .retire_cnt  (retire_cnt),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0040_0000: return 32'h2408_0001;
            32'h0040_0004: return 32'h1111_1111;
            32'h0040_0008: return 32'h2222_2222;
            32'h0040_000C: return 32'h3333_3333;
            32'h0040_0010: return 32'h1000_FFFC;
            32'h0040_0014: return 32'h4444_4444;
            32'h0040_0018: return 32'h5555_5555;
            32'h0040_001C: return 32'h6666_6666;
            32'h0040_0020: return 32'h0810_0040;
            32'h0040_0100: return 32'h7777_7777;
            32'h0040_0200: return 32'h8888_8888;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        exp_fetch_q.push_back(a);
        exp_pc_q.push_back(a);
        exp_ins_q.push_back(mem_rd(a));
    endtask

    task automatic clear_q();
        exp_fetch_q.delete();
        exp_pc_q.delete();
        exp_ins_q.delete();
    endtask

    task automatic wait_valid();
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (instr_valid) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: got 0 expected 1");
        end
    endtask

    task automatic retire(input logic b, input logic j, input logic r,
                          input logic [31:0] rs, input logic [31:0] nxt,
                          input bit fetch_next);
        wait_valid();
        instr_ready = 1'b1;
        br_taken    = b;
        jmp         = j;
        jr          = r;
        rs_val      = rs;
        if (fetch_next) expect_fetch(nxt);
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        br_taken    = 1'b0;
        jmp         = 1'b0;
        jr          = 1'b0;
        rs_val      = 32'd0;
        n_ret++;
    endtask

    // Instruction memory model with programmable ack latency
    always @(negedge clk) begin
        if (mem_en) begin
            if (imem_req) begin
                if (wait_cnt >= lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_rd(imem_addr);
                    wait_cnt   = 0;
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: compare each new request and each newly held instr
    always @(negedge clk) begin
        if (rst) begin
            req_d   = 1'b0;
            valid_d = 1'b0;
        end else begin
            if (imem_req && !req_d) begin
                if (exp_fetch_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fetch: got %h expected none",
                             imem_addr);
                end else begin
                    cur_addr = exp_fetch_q.pop_front();
                    chk("fetch_addr", imem_addr, cur_addr);
                end
            end else if (imem_req) begin
                chk("addr_stable", imem_addr, cur_addr);
            end
            if (instr_valid && !valid_d) begin
                if (exp_pc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got %h expected none",
                             instr);
                end else begin
                    chk("hold_pc", pc, exp_pc_q.pop_front());
                    chk("hold_instr", instr, exp_ins_q.pop_front());
                end
            end
            req_d   = imem_req;
            valid_d = instr_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        br_taken    = 1'b0;
        jmp         = 1'b0;
        jr          = 1'b0;
        rs_val      = 32'd0;

        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h0040_0000);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_pc4", pc_plus4, 32'h0040_0004);

        @(posedge clk);
        #1 rst = 1'b0;
        expect_fetch(32'h0040_0000);
        @(negedge clk);
        chk("c1_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        chk("c2_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        chk("c3_valid", {31'd0, instr_valid}, 32'd1);
        chk("c3_pc4", pc_plus4, 32'h0040_0004);

        lat = 3;
        retire(0, 0, 0, 0, 32'h0040_0004, 1);
        retire(0, 0, 0, 0, 32'h0040_0008, 1);
        retire(0, 0, 0, 0, 32'h0040_000C, 1);
        @(negedge clk);
        chk("retire3", retire_cnt, 32'd3);

        lat = 1;
        retire(0, 0, 0, 0, 32'h0040_0010, 1);
        retire(1, 0, 0, 0, 32'h0040_0004, 1);
        retire(0, 0, 0, 0, 32'h0040_0008, 1);
        retire(0, 0, 0, 0, 32'h0040_000C, 1);
        retire(0, 0, 0, 0, 32'h0040_0010, 1);
        retire(0, 0, 0, 0, 32'h0040_0014, 1);
        retire(0, 0, 0, 0, 32'h0040_0018, 1);
        retire(0, 0, 0, 0, 32'h0040_001C, 1);
        retire(0, 0, 0, 0, 32'h0040_0020, 1);
        retire(1, 1, 0, 0, 32'h0040_0100, 1);

`ifdef FETCH_ALIGN_CHECK_EN
        retire(0, 0, 1, 32'h0040_0203, 32'd0, 0);
        repeat (3) @(negedge clk);
        chk("err_flag", {31'd0, fetch_err}, 32'd1);
        chk("err_req", {31'd0, imem_req}, 32'd0);
        chk("err_valid", {31'd0, instr_valid}, 32'd0);
        chk("err_pc", pc, 32'h0040_0100);
        chk("err_retire", retire_cnt, n_ret);
`else
        retire(0, 0, 1, 32'h0040_0203, 32'h0040_0200, 1);
        wait_valid();
        chk("jr_retire", retire_cnt, n_ret);
        chk("jr_noerr", {31'd0, fetch_err}, 32'd0);
`endif

        // Abandon a pending fetch with reset, then ignore a stray ack
        @(negedge clk);
        #2 rst = 1'b1;
        clear_q();
        lat = 9;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_fetch_q.push_back(32'h0040_0000);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (imem_req) seen = 1'b1;
        end
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("req_drop", {31'd0, imem_req}, 32'd0);
        chk("rst2_retire", retire_cnt, 32'd0);
        clear_q();
        @(posedge clk);
        #1 rst = 1'b0;
        mem_en = 1'b0;
        expect_fetch(32'h0040_0000);
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hBADB_AD00;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        lat      = 0;
        mem_en   = 1'b1;
        @(negedge clk);
        chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        chk("late_ack_instr", instr, 32'd0);
        chk("late_ack_retire", retire_cnt, 32'd0);
        n_ret = 0;

        // PC wrap at the top of the address space
        retire(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1);
        wait_valid();
        chk("wrap_pc4", pc_plus4, 32'd0);
        retire(0, 0, 0, 0, 32'd0, 1);
        wait_valid();
        chk("wrap_retire", retire_cnt, 32'd2);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
